// File: rtl/pipe_generator.sv
// Single scrolling pipe: moving X edges, LFSR-randomised gap, score and pass pulse.
// Optional macro PIPE_SPEEDUP_EN raises scroll speed by 1 px per 8 points, capped at MAX_SPEED.
module pipe_generator #(
  parameter int SCREEN_W    = 640,
  parameter int PIPE_W      = 60,
  parameter int GAP_H       = 120,
  parameter int GAP_MIN_TOP = 60,
  parameter int SPEED       = 2,
  parameter int MAX_SPEED   = 4
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       Start,
  input  logic       Tick,
  input  logic       Halt,
  input  logic [9:0] Bird_X_L,
  output logic [9:0] X_Edge_Left,
  output logic [9:0] X_Edge_Right,
  output logic [9:0] Y_Edge_Top,
  output logic [9:0] Y_Edge_Bottom,
  output logic [7:0] Score,
  output logic       Pipe_Passed,
  output logic       Active
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_RUN    = 3'b010,
    S_FROZEN = 3'b100
  } state_t;

  localparam logic [9:0] PARK_X   = 10'(SCREEN_W - PIPE_W);
  localparam logic [9:0] RIGHT_X  = 10'(SCREEN_W);
  localparam logic [9:0] PIPE_W10 = 10'(PIPE_W);
  localparam logic [9:0] GAP_H10  = 10'(GAP_H);
  localparam logic [9:0] GAP_MIN  = 10'(GAP_MIN_TOP);

  state_t     state_q;
  logic [7:0] lfsr_q;
  logic       scored_q;

  logic [7:0] lfsr_next;
  logic [9:0] speed;
  logic [9:0] moved_left;
  logic [9:0] moved_right;
  logic [9:0] new_top;

`ifdef PIPE_SPEEDUP_EN
  logic [9:0] boosted;
`endif

  always_comb begin
`ifdef PIPE_SPEEDUP_EN
    // Derived from the registered score, so a new speed applies from the tick after scoring.
    boosted = 10'(SPEED) + {5'd0, Score[7:3]};
    speed   = (boosted > 10'(MAX_SPEED)) ? 10'(MAX_SPEED) : boosted;
`else
    speed   = 10'(SPEED);
`endif
    lfsr_next   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    moved_left  = X_Edge_Left - speed;
    moved_right = moved_left + PIPE_W10;
    new_top     = GAP_MIN + {2'b00, lfsr_q};
  end

  // NOTE: every register here, including the LFSR, has an explicit reset value and
  // is written only with non-blocking assignments so all edges update together.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      lfsr_q        <= 8'hA5;
      scored_q      <= 1'b0;
      X_Edge_Left   <= PARK_X;
      X_Edge_Right  <= RIGHT_X;
      Y_Edge_Top    <= GAP_MIN;
      Y_Edge_Bottom <= GAP_MIN + GAP_H10;
      Score         <= 8'd0;
      Pipe_Passed   <= 1'b0;
      Active        <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_next;
      Pipe_Passed <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (Start) begin
            state_q       <= S_RUN;
            Active        <= 1'b1;
            Score         <= 8'd0;
            scored_q      <= 1'b0;
            Y_Edge_Top    <= new_top;
            Y_Edge_Bottom <= new_top + GAP_H10;
          end
        end
        S_RUN: begin
          if (Halt) begin
            state_q <= S_FROZEN;
            Active  <= 1'b0;
          end else if (Tick) begin
            if (X_Edge_Left < speed) begin
              X_Edge_Left   <= PARK_X;
              X_Edge_Right  <= RIGHT_X;
              Y_Edge_Top    <= new_top;
              Y_Edge_Bottom <= new_top + GAP_H10;
              scored_q      <= 1'b0;
            end else begin
              X_Edge_Left  <= moved_left;
              X_Edge_Right <= moved_right;
              if (!scored_q && (moved_right < Bird_X_L)) begin
                scored_q    <= 1'b1;
                Score       <= (Score == 8'hFF) ? Score : Score + 8'd1;
                Pipe_Passed <= 1'b1;
              end
            end
          end
        end
        S_FROZEN: begin
          if (!Halt) begin
            state_q      <= S_IDLE;
            X_Edge_Left  <= PARK_X;
            X_Edge_Right <= RIGHT_X;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_generator.sv
// Self-checking bench for pipe_generator: directed steps plus randomised scrolling,
// compared every cycle against a behavioural game model.
module tb_pipe_generator;

  logic       Clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       Start = 1'b0;
  logic       Tick = 1'b0;
  logic       Halt = 1'b0;
  logic [9:0] Bird_X_L = 10'd0;
  logic [9:0] X_Edge_Left, X_Edge_Right, Y_Edge_Top, Y_Edge_Bottom;
  logic [7:0] Score;
  logic       Pipe_Passed, Active;

  pipe_generator dut (
    .Clk          (Clk),
    .reset_n      (reset_n),
    .Start        (Start),
    .Tick         (Tick),
    .Halt         (Halt),
    .Bird_X_L     (Bird_X_L),
    .X_Edge_Left  (X_Edge_Left),
    .X_Edge_Right (X_Edge_Right),
    .Y_Edge_Top   (Y_Edge_Top),
    .Y_Edge_Bottom(Y_Edge_Bottom),
    .Score        (Score),
    .Pipe_Passed  (Pipe_Passed),
    .Active       (Active)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = waiting, 1 = playing, 2 = frozen.
  int       m_phase, m_left, m_top, m_score, m_scored, m_pass, m_respawn;
  bit [7:0] m_rng;

  function automatic int cur_speed(int score);
`ifdef PIPE_SPEEDUP_EN
    return (2 + score / 8 > 4) ? 4 : 2 + score / 8;
`else
    return 2 + 0 * score;
`endif
  endfunction

  task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_left = 580; m_top = 60; m_score = 0;
    m_scored = 0; m_pass = 0; m_respawn = 0; m_rng = 8'hA5;
  endtask

  task automatic check_all(string tag);
    check({tag, "_xl"},     32'(X_Edge_Left),   32'(m_left));
    check({tag, "_xr"},     32'(X_Edge_Right),  32'(m_left + 60));
    check({tag, "_yt"},     32'(Y_Edge_Top),    32'(m_top));
    check({tag, "_yb"},     32'(Y_Edge_Bottom), 32'(m_top + 120));
    check({tag, "_score"},  32'(Score),         32'(m_score));
    check({tag, "_pass"},   32'(Pipe_Passed),   32'(m_pass));
    check({tag, "_active"}, 32'(Active),        32'(m_phase == 1));
  endtask

  // One clock: inputs applied at the negedge, model advanced at the posedge, outputs checked 1ns later.
  task automatic cycle(string tag, bit st, bit tk, bit ht);
    int       s;
    bit [7:0] rng_now;
    Start = st; Tick = tk; Halt = ht;
    @(posedge Clk);
    rng_now   = m_rng;
    m_rng     = {m_rng[6:0], ^(m_rng & 8'hB8)};
    m_pass    = 0;
    m_respawn = 0;
    case (m_phase)
      0: if (st) begin
        m_phase = 1; m_score = 0; m_scored = 0; m_top = 60 + int'(rng_now);
      end
      1: if (ht) m_phase = 2;
         else if (tk) begin
           s = cur_speed(m_score);
           if (m_left < s) begin
             m_left = 580; m_top = 60 + int'(rng_now); m_scored = 0; m_respawn = 1;
           end else begin
             m_left -= s;
             if (!m_scored && (m_left + 60 < int'(Bird_X_L))) begin
               m_scored = 1; m_pass = 1;
               if (m_score < 255) m_score++;
             end
           end
         end
      default: if (!ht) begin m_phase = 0; m_left = 580; end
    endcase
    #1;
    check_all(tag);
    @(negedge Clk);
  endtask

  task automatic do_reset(string tag);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge Clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int pulses;
    logic [9:0] held_left;
    #2;
    do_reset("por");

    // Halt is ignored while waiting; pipe stays parked.
    for (int i = 0; i < 4; i++) cycle("idle_halt", 1'b0, 1'b1, 1'b1);

    // Start together with Tick: game begins, no move.
    Bird_X_L = 10'd100;
    cycle("start", 1'b1, 1'b1, 1'b0);
    check("start_no_move", 32'(X_Edge_Left), 32'd580);
    check("start_gap_range", 32'(Y_Edge_Top >= 10'd60 && Y_Edge_Top <= 10'd315), 32'd1);
    cycle("first_tick", 1'b0, 1'b1, 1'b0);
    check("first_xl", 32'(X_Edge_Left), 32'd578);
    check("first_xr", 32'(X_Edge_Right), 32'd638);

    // Scroll the first pipe past the bird and through respawn.
    pulses = 0;
    for (int i = 0; i < 2000 && !m_respawn; i++) begin
      cycle("scroll", 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      if (Pipe_Passed) pulses++;
    end
    check("one_pulse_per_pipe", 32'(pulses), 32'd1);
    check("score_after_pipe", 32'(Score), 32'd1);
    check("respawn_xl", 32'(X_Edge_Left), 32'd580);
    check("respawn_gap_range", 32'(Y_Edge_Top >= 10'd60 && Y_Edge_Top <= 10'd315), 32'd1);

    for (int i = 0; i < 30; i++) cycle("scroll2", 1'b0, 1'b1, 1'b0);

    // Halt beats Tick; everything holds while frozen.
    held_left = X_Edge_Left;
    cycle("halt_tick", 1'b0, 1'b1, 1'b1);
    check("halt_no_move", 32'(X_Edge_Left), 32'(held_left));
    for (int i = 0; i < 10; i++) cycle("frozen", 1'b0, 1'b1, 1'b1);
    cycle("release", 1'b0, 1'b1, 1'b0);
    check("release_park", 32'(X_Edge_Left), 32'd580);
    check("release_score", 32'(Score), 32'd1);

    // Randomised games with random bird positions and tick patterns.
    for (int g = 0; g < 3; g++) begin
      Bird_X_L = 10'($urandom_range(0, 640));
      for (int i = 0; i < int'($urandom_range(0, 5)); i++) cycle("wait", 1'b0, 1'b0, 1'b0);
      cycle("g_start", 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      for (int i = 0; i < 900; i++) begin
        if ($urandom_range(0, 150) == 0) Bird_X_L = 10'($urandom_range(0, 640));
        cycle("game", 1'b0, 1'($urandom_range(0, 3) != 0), 1'b0);
      end
      cycle("g_halt", 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) cycle("g_frozen", 1'b0, 1'($urandom_range(0, 1)), 1'b1);
      cycle("g_release", 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of a game.
    Bird_X_L = 10'd300;
    cycle("r_start", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) cycle("r_game", 1'b0, 1'b1, 1'b0);
    #2;
    do_reset("mid_reset");
    for (int i = 0; i < 5; i++) cycle("post_reset", 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
